// File: rtl/binary_counter_pkg.sv
// Shared types and key indices for the LED binary counter controller.
package binary_counter_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    STEP    = 2'd2
  } state_t;

  typedef logic [1:0] speed_t;

  localparam int KEY_RUN   = 0;
  localparam int KEY_DIR   = 1;
  localparam int KEY_STEP  = 2;
  localparam int KEY_SPEED = 3;
  localparam int N_KEYS    = 4;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchronizer, stability counter and single-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 270_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples disagreeing with the accepted level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/binary_counter_ctrl.sv
// Run/pause/step sequencer, prescaler and counter for the LED binary counter.
// Define AUTO_REVERSE_EN to reflect at the ends instead of wrapping.
module binary_counter_ctrl
  import binary_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 270_000,
  parameter int BASE_DIV     = 2_700_000,
  parameter int W_CNT        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       key,
  output logic [W_CNT-1:0] cnt_o,
  output logic             run_o,
  output logic             dir_up_o,
  output logic [1:0]       speed_o,
  output logic             tick_o
);

  localparam int PW = $clog2(BASE_DIV);

  logic [N_KEYS-1:0] press;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk_i  (clock),
      .rst_i  (reset),
      .key_i  (key[k]),
      .press_o(press[k])
    );
  end

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [PW-1:0]    term;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  speed_t           speed_q, speed_d;
  logic             tick;
  logic             upd;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PAUSED: begin
        if (press[KEY_RUN])       state_d = RUNNING;
        else if (press[KEY_STEP]) state_d = STEP;
      end
      RUNNING: begin
        if (press[KEY_RUN]) state_d = PAUSED;
      end
      STEP:    state_d = PAUSED;
      default: state_d = PAUSED;
    endcase
  end

  // Restart on any non-running cycle, speed change or terminal count
  always_comb begin
    term    = PW'((BASE_DIV >> speed_q) - 1);
    tick    = (state_q == RUNNING) && (presc_q == term);
    upd     = tick || (state_q == STEP);
    presc_d = '0;
    if (state_q == RUNNING && !tick && !press[KEY_SPEED]) begin
      presc_d = presc_q + 1'b1;
    end
    speed_d = speed_q + speed_t'(press[KEY_SPEED]);
  end

  always_comb begin
    dir_d = dir_q ^ press[KEY_DIR];
    cnt_d = cnt_q;
    if (upd) begin
`ifdef AUTO_REVERSE_EN
      if (dir_q && cnt_q == {W_CNT{1'b1}}) begin
        cnt_d = cnt_q - 1'b1;
        dir_d = 1'b0;
      end else if (!dir_q && cnt_q == '0) begin
        cnt_d = W_CNT'(1);
        dir_d = 1'b1;
      end else begin
        cnt_d = dir_q ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
`else
      cnt_d = dir_q ? cnt_q + 1'b1 : cnt_q - 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PAUSED;
      presc_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign run_o    = (state_q == RUNNING);
  assign dir_up_o = dir_q;
  assign speed_o  = speed_q;
  assign tick_o   = tick;

endmodule

// File: tb/tb_binary_counter_ctrl.sv
// Bench for binary_counter_ctrl with a key-history reference model.
module tb_binary_counter_ctrl;

  localparam int D    = 4;
  localparam int BASE = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = 4'h0;
  logic [7:0] cnt_o;
  logic       run_o, dir_up_o, tick_o;
  logic [1:0] speed_o;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  binary_counter_ctrl #(
    .DEBOUNCE_CYC(D),
    .BASE_DIV    (BASE),
    .W_CNT       (8)
  ) dut (
    .clock   (clk),
    .reset   (reset),
    .key     (key),
    .cnt_o   (cnt_o),
    .run_o   (run_o),
    .dir_up_o(dir_up_o),
    .speed_o (speed_o),
    .tick_o  (tick_o)
  );

  // Model: a key level is accepted once its last D synced samples agree
  logic [D+1:0] m_hist [4];
  logic [3:0]   m_lvl = 4'h0, m_lvl_d = 4'h0, m_press = 4'h0;
  int           m_mode = 0;
  int           m_pc = 0;
  logic [7:0]   m_cnt = 8'd0;
  logic         m_dir = 1'b1;
  logic [1:0]   m_spd = 2'd0;

  always @(posedge clk) begin
    logic       tk, up, nd;
    logic [7:0] nc;
    logic [3:0] nl, np;
    logic [D-1:0] win;
    int         nm;
    if (reset) begin
      for (int k = 0; k < 4; k++) m_hist[k] = '0;
      m_lvl = 0; m_lvl_d = 0; m_press = 0;
      m_mode = 0; m_pc = 0; m_cnt = 0; m_dir = 1; m_spd = 0;
    end else begin
      tk = (m_mode == 1) && (m_pc == (BASE >> m_spd) - 1);
      up = tk || (m_mode == 2);
      nd = m_dir ^ m_press[1];
      nc = m_cnt;
      if (up) begin
        nc = m_dir ? m_cnt + 8'd1 : m_cnt - 8'd1;
`ifdef AUTO_REVERSE_EN
        if (m_dir && m_cnt == 8'd255) begin nc = 8'd254; nd = 1'b0; end
        if (!m_dir && m_cnt == 8'd0) begin nc = 8'd1; nd = 1'b1; end
`endif
      end
      if (m_mode == 0)      nm = m_press[0] ? 1 : (m_press[2] ? 2 : 0);
      else if (m_mode == 1) nm = m_press[0] ? 0 : 1;
      else                  nm = 0;
      m_pc = (m_mode == 1 && nm == 1 && !m_press[3] && !tk) ? m_pc + 1 : 0;
      m_spd = m_spd + {1'b0, m_press[3]};
      m_cnt = nc;
      m_dir = nd;
      m_mode = nm;
      for (int k = 0; k < 4; k++) begin
        m_hist[k] = {m_hist[k][D:0], key[k]};
        win = m_hist[k][D+1:2];
        nl[k] = (&win) ? 1'b1 : ((|win) ? m_lvl[k] : 1'b0);
        np[k] = m_lvl[k] & ~m_lvl_d[k];
      end
      m_lvl_d = m_lvl;
      m_lvl = nl;
      m_press = np;
    end
  end

  logic [12:0] dut_v, exp_v;
  localparam logic [12:0] RST_V = {8'd0, 1'b0, 1'b1, 2'd0, 1'b0};
  assign dut_v = {cnt_o, run_o, dir_up_o, speed_o, tick_o};
  assign exp_v = {m_cnt, (m_mode == 1), m_dir, m_spd,
                  (m_mode == 1) && (m_pc == (BASE >> m_spd) - 1)};

  task automatic test_reset;
    reset = 1'b1;
    key = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vecs++;
      if (dut_v !== RST_V) begin
        errs++;
        $display("FAIL reset c=%0d got=%h exp=%h", c, dut_v, RST_V);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_run_tick;
    int first = -1;
    for (int c = 0; c < 60; c++) begin
      key[0] = (c < 10);
      @(negedge clk);
      vecs++;
      if (dut_v !== exp_v) begin
        errs++;
        $display("FAIL run_tick c=%0d got=%h exp=%h", c, dut_v, exp_v);
      end
      if (run_o === 1'b1 && first < 0) first = c;
      if (c == 22) begin
        vecs++;
        if (tick_o !== 1'b1) begin
          errs++;
          $display("FAIL first_tick got=%b exp=1", tick_o);
        end
      end
    end
    vecs++;
    if (first != 7) begin
      errs++;
      $display("FAIL run_latency got=%0d exp=7", first);
    end
    vecs++;
    if (cnt_o !== 8'd3) begin
      errs++;
      $display("FAIL run_cnt got=%0d exp=3", cnt_o);
    end
  endtask

  task automatic test_speed;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 16; c++) begin
        key[3] = (c < 6);
        @(negedge clk);
        vecs++;
        if (dut_v !== exp_v) begin
          errs++;
          $display("FAIL speed p=%0d c=%0d got=%h exp=%h", p, c, dut_v, exp_v);
        end
      end
      if (p == 0) begin
        vecs++;
        if (speed_o !== 2'd1) begin
          errs++;
          $display("FAIL speed_one got=%0d exp=1", speed_o);
        end
      end
    end
    vecs++;
    if (speed_o !== 2'd0) begin
      errs++;
      $display("FAIL speed_wrap got=%0d exp=0", speed_o);
    end
  endtask

  task automatic test_dir_step;
    test_reset();
    for (int p = 1; p <= 2; p++) begin
      for (int c = 0; c < 16; c++) begin
        key[p] = (c < 6);
        @(negedge clk);
        vecs++;
        if (dut_v !== exp_v) begin
          errs++;
          $display("FAIL dir_step p=%0d c=%0d got=%h exp=%h", p, c, dut_v, exp_v);
        end
      end
    end
    vecs++;
`ifdef AUTO_REVERSE_EN
    if (cnt_o !== 8'd1 || dir_up_o !== 1'b1) begin
      errs++;
      $display("FAIL reflect got=%0d/%b exp=1/1", cnt_o, dir_up_o);
    end
`else
    if (cnt_o !== 8'd255 || dir_up_o !== 1'b0) begin
      errs++;
      $display("FAIL wrap_down got=%0d/%b exp=255/0", cnt_o, dir_up_o);
    end
`endif
  endtask

  task automatic test_glitch;
    logic [7:0] e1, e2;
`ifdef AUTO_REVERSE_EN
    e1 = 8'd1; e2 = 8'd2;
`else
    e1 = 8'd255; e2 = 8'd254;
`endif
    for (int c = 0; c < 40; c++) begin
      key[2] = (c < 3) || (c >= 15 && c < 29);
      @(negedge clk);
      vecs++;
      if (dut_v !== exp_v) begin
        errs++;
        $display("FAIL glitch c=%0d got=%h exp=%h", c, dut_v, exp_v);
      end
      if (c == 14) begin
        vecs++;
        if (cnt_o !== e1) begin
          errs++;
          $display("FAIL glitch_step got=%0d exp=%0d", cnt_o, e1);
        end
      end
    end
    vecs++;
    if (cnt_o !== e2) begin
      errs++;
      $display("FAIL held_step got=%0d exp=%0d", cnt_o, e2);
    end
  endtask

  task automatic test_mid_reset;
    bit hit = 0;
    test_reset();
    for (int c = 0; c < 200 && !hit; c++) begin
      key[0] = (c < 10);
      @(negedge clk);
      vecs++;
      if (dut_v !== exp_v) begin
        errs++;
        $display("FAIL mid_run c=%0d got=%h exp=%h", c, dut_v, exp_v);
      end
      if (cnt_o === 8'd5) hit = 1;
    end
    key = 4'h0;
    vecs++;
    if (!hit) begin
      errs++;
      $display("FAIL cnt5_timeout got=%0d exp=5", cnt_o);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++;
    if (dut_v !== RST_V) begin
      errs++;
      $display("FAIL mid_reset got=%h exp=%h", dut_v, RST_V);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vecs++;
      if (tick_o !== 1'b0 || dut_v !== exp_v) begin
        errs++;
        $display("FAIL post_reset c=%0d got=%h exp=%h", c, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_random;
    int left [4] = '{0, 0, 0, 0};
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (left[k] == 0) begin
          key[k] = 1'($urandom_range(0, 1));
          left[k] = $urandom_range(1, 12);
        end
        left[k]--;
      end
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      vecs++;
      if (dut_v !== exp_v) begin
        errs++;
        $display("FAIL random c=%0d got=%h exp=%h", c, dut_v, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_speed();
    test_dir_step();
    test_glitch();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
